// File: rtl/life_pkg.sv
// Shared constants, types and helpers for the 8x8 toroidal Game of Life engine.
package life_pkg;

    localparam int GRID_N = 8;
    localparam int CELLS  = 64;

    localparam logic [63:0] DEFAULT_SEED = 64'hACE1_2468_1357_BDF9;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        LOAD = 2'b10
    } mode_e;

    // Row 0 / column 0 is the top-left cell, which lives in bit 63.
    function automatic int idx(input int r, input int c);
        return 63 - (8 * r + c);
    endfunction

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Single-cell Life rule: survive on 2 or 3 live neighbours, birth on exactly 3.
module life_cell_rule (
    input  logic [7:0] nbr_i,
    input  logic       cur_i,
    output logic       next_o
);

    logic [3:0] cnt_s;

    // Population count of the eight neighbours.
    always_comb begin
        cnt_s = 4'd0;
        for (int k = 0; k < 8; k++) begin
            cnt_s = cnt_s + {3'd0, nbr_i[k]};
        end
    end

    assign next_o = (cnt_s == 4'd3) | (cur_i & (cnt_s == 4'd2));

endmodule

// File: rtl/life_grid_engine.sv
// 8x8 toroidal Game of Life grid with an inline 64-bit Fibonacci LFSR seed source.
module life_grid_engine
    import life_pkg::*;
#(
    parameter logic [63:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lfsr_load,
    input  logic        start,
    output logic [63:0] q,
    output logic [63:0] grid_evolve,
    output logic [63:0] debug,
    output logic [1:0]  debug2
);

    logic [63:0] grid_q;
    logic [63:0] grid_d;
    logic [63:0] lfsr_q;
    logic [63:0] lfsr_d;
    mode_e       mode_q;
    mode_e       mode_d;

    // Next-state selection: a load takes the pre-shift LFSR value and beats start.
    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        grid_d = grid_q;
        mode_d = IDLE;
        if (lfsr_load) begin
            grid_d = lfsr_q;
            mode_d = LOAD;
        end else if (start) begin
            grid_d = grid_evolve;
            mode_d = RUN;
        end else begin
            grid_d = grid_q;
            mode_d = IDLE;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grid_q <= 64'd0;
            lfsr_q <= SEED;
            mode_q <= IDLE;
        end else begin
            grid_q <= grid_d;
            lfsr_q <= lfsr_d;
            mode_q <= mode_d;
        end
    end

    // Neighbour indices wrap modulo 8 in both directions.
    for (genvar r = 0; r < GRID_N; r++) begin : g_row
        for (genvar c = 0; c < GRID_N; c++) begin : g_col
            localparam int RU = (r + GRID_N - 1) % GRID_N;
            localparam int RD = (r + 1) % GRID_N;
            localparam int CL = (c + GRID_N - 1) % GRID_N;
            localparam int CR = (c + 1) % GRID_N;

            life_cell_rule u_cell (
                .nbr_i ({grid_q[idx(RU, CL)], grid_q[idx(RU, c)], grid_q[idx(RU, CR)],
                         grid_q[idx(r,  CL)],                     grid_q[idx(r,  CR)],
                         grid_q[idx(RD, CL)], grid_q[idx(RD, c)], grid_q[idx(RD, CR)]}),
                .cur_i  (grid_q[idx(r, c)]),
                .next_o (grid_evolve[idx(r, c)])
            );
        end
    end

    assign q      = grid_q;
    assign debug  = lfsr_q;
    assign debug2 = mode_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: four instances with different seeds share stimulus.
module tb_life_grid_engine;

    localparam logic [63:0] SEED_DEF = 64'hACE1_2468_1357_BDF9;
    localparam logic [63:0] SEED_BLK = 64'h0000_0038_0000_0000;
    localparam logic [63:0] VERT_BLK = 64'h0000_1010_1000_0000;
    localparam logic [63:0] SEED_SQ  = 64'h0000_0018_1800_0000;
    localparam logic [63:0] SEED_GL  = 64'h4020_E000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic lfsr_load = 1'b0;
    logic start = 1'b0;

    logic [63:0] q_def, ev_def, dbg_def;
    logic [63:0] q_blk, ev_blk, dbg_blk;
    logic [63:0] q_sq,  ev_sq,  dbg_sq;
    logic [63:0] q_gl,  ev_gl,  dbg_gl;
    logic [1:0]  md_def, md_blk, md_sq, md_gl;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] lfsr_model;

    always #5 clk = ~clk;

    life_grid_engine #(.SEED(SEED_DEF)) dut_def (.clk(clk), .reset(reset), .lfsr_load(lfsr_load), .start(start),
        .q(q_def), .grid_evolve(ev_def), .debug(dbg_def), .debug2(md_def));
    life_grid_engine #(.SEED(SEED_BLK)) dut_blk (.clk(clk), .reset(reset), .lfsr_load(lfsr_load), .start(start),
        .q(q_blk), .grid_evolve(ev_blk), .debug(dbg_blk), .debug2(md_blk));
    life_grid_engine #(.SEED(SEED_SQ)) dut_sq (.clk(clk), .reset(reset), .lfsr_load(lfsr_load), .start(start),
        .q(q_sq), .grid_evolve(ev_sq), .debug(dbg_sq), .debug2(md_sq));
    life_grid_engine #(.SEED(SEED_GL)) dut_gl (.clk(clk), .reset(reset), .lfsr_load(lfsr_load), .start(start),
        .q(q_gl), .grid_evolve(ev_gl), .debug(dbg_gl), .debug2(md_gl));

    function automatic logic [63:0] step(input logic [63:0] s);
        logic fb;
        fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return (s << 1) | {63'd0, fb};
    endfunction

    // Reference Life generation written as explicit neighbour loops.
    function automatic logic [63:0] life_next(input logic [63:0] g);
        logic [63:0] res;
        int n;
        res = 64'd0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0)) begin
                            if (g[63 - (8 * ((r + dr + 8) % 8) + ((c + dc + 8) % 8))]) n++;
                        end
                    end
                end
                if (n == 3 || (n == 2 && g[63 - (8 * r + c)])) res[63 - (8 * r + c)] = 1'b1;
            end
        end
        return res;
    endfunction

    // Expected LFSR state of the default-seed instance.
    always @(posedge clk or negedge reset) begin
        if (!reset) lfsr_model <= SEED_DEF;
        else        lfsr_model <= step(lfsr_model);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        tick();
        reset = 1'b0;
        lfsr_load = 1'b0;
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        hold_reset();
        vectors++;
        if (q_def !== 64'd0 || dbg_def !== SEED_DEF || md_def !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: q=%h debug=%h debug2=%b want q=0 debug=%h debug2=00", q_def, dbg_def, md_def, SEED_DEF);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if (dbg_def !== step(SEED_DEF) || q_def !== 64'd0 || md_def !== 2'b00) begin
            miscompares++;
            $display("FAIL lfsr_first_step: debug=%h q=%h debug2=%b want debug=%h q=0 debug2=00",
                     dbg_def, q_def, md_def, step(SEED_DEF));
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dbg_def !== lfsr_model) begin
                miscompares++;
                $display("FAIL lfsr_step%0d: debug=%h want %h", i, dbg_def, lfsr_model);
            end
        end
    endtask

    task automatic test_blinker();
        hold_reset();
        lfsr_load = 1'b1;
        reset = 1'b1;
        tick();
        lfsr_load = 1'b0;
        start = 1'b1;
        vectors++;
        if (q_blk !== SEED_BLK || ev_blk !== VERT_BLK || md_blk !== 2'b10) begin
            miscompares++;
            $display("FAIL blinker_load: q=%h evolve=%h debug2=%b want q=%h evolve=%h debug2=10",
                     q_blk, ev_blk, md_blk, SEED_BLK, VERT_BLK);
        end
        tick();
        vectors++;
        if (q_blk !== VERT_BLK || md_blk !== 2'b01) begin
            miscompares++;
            $display("FAIL blinker_gen1: q=%h debug2=%b want q=%h debug2=01", q_blk, md_blk, VERT_BLK);
        end
        tick();
        vectors++;
        if (q_blk !== SEED_BLK) begin
            miscompares++;
            $display("FAIL blinker_gen2: q=%h want %h", q_blk, SEED_BLK);
        end
    endtask

    task automatic test_block();
        hold_reset();
        lfsr_load = 1'b1;
        reset = 1'b1;
        tick();
        lfsr_load = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (q_sq !== SEED_SQ || ev_sq !== SEED_SQ) begin
                miscompares++;
                $display("FAIL block_gen%0d: q=%h evolve=%h want %h", i, q_sq, ev_sq, SEED_SQ);
            end
        end
    endtask

    task automatic test_glider();
        logic [63:0] exp_g;
        hold_reset();
        lfsr_load = 1'b1;
        reset = 1'b1;
        tick();
        lfsr_load = 1'b0;
        start = 1'b1;
        exp_g = SEED_GL;
        for (int i = 0; i < 32; i++) begin
            vectors++;
            if (ev_gl !== life_next(exp_g)) begin
                miscompares++;
                $display("FAIL glider_evolve%0d: evolve=%h want %h", i, ev_gl, life_next(exp_g));
            end
            tick();
            exp_g = life_next(exp_g);
        end
        vectors++;
        if (q_gl !== SEED_GL) begin
            miscompares++;
            $display("FAIL glider_wrap32: q=%h want %h", q_gl, SEED_GL);
        end
    endtask

    task automatic test_load_and_start();
        logic [63:0] exp_q;
        hold_reset();
        lfsr_load = 1'b1;
        start = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q = lfsr_model;
            tick();
            vectors++;
            if (q_def !== exp_q || dbg_def !== lfsr_model || md_def !== 2'b10) begin
                miscompares++;
                $display("FAIL load_priority%0d: q=%h debug=%h debug2=%b want q=%h debug=%h debug2=10",
                         i, q_def, dbg_def, md_def, exp_q, lfsr_model);
            end
        end
        lfsr_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_q = life_next(exp_q);
            vectors++;
            if (q_def !== exp_q || md_def !== 2'b01) begin
                miscompares++;
                $display("FAIL run_after_load%0d: q=%h debug2=%b want q=%h debug2=01", i, q_def, md_def, exp_q);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (q_def !== 64'd0 || dbg_def !== SEED_DEF || md_def !== 2'b00 || q_blk !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run: q=%h debug=%h debug2=%b want q=0 debug=%h debug2=00",
                     q_def, dbg_def, md_def, SEED_DEF);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (q_def !== 64'd0 || ev_def !== 64'd0 || md_def !== 2'b01 || dbg_def !== lfsr_model) begin
                miscompares++;
                $display("FAIL empty_stays_empty%0d: q=%h evolve=%h debug2=%b debug=%h want q=0 evolve=0 debug2=01 debug=%h",
                         i, q_def, ev_def, md_def, dbg_def, lfsr_model);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_glider();
        test_load_and_start();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
